// File: rtl/sm_ramp_ctrl_if.sv
// Command / drive bundle between a move requester, the ramp sequencer and the
// stepper pulse generator.
//   master : requester side (drives the command and the returned step pulse)
//   slave  : sequencer side (drives enable, period, load strobe and status)
// Command: start, stop_req, target_steps, dir_in, n_start, n_min, n_delta
// Return : drv_step (step pulse from the pulse generator)
// Drive  : drv_enable_sm, n, n_load, dir_out
// Status : busy, done, steps_done
interface sm_ramp_ctrl_if #(
  parameter int unsigned Size = 16,
  parameter int unsigned CntW = 32
);
  logic            start;
  logic            stop_req;
  logic [CntW-1:0] target_steps;
  logic            dir_in;
  logic [Size:0]   n_start;
  logic [Size:0]   n_min;
  logic [Size:0]   n_delta;
  logic            drv_step;

  logic            drv_enable_sm;
  logic [Size:0]   n;
  logic            n_load;
  logic            dir_out;
  logic            busy;
  logic            done;
  logic [CntW-1:0] steps_done;

  modport master (
    output start, stop_req, target_steps, dir_in, n_start, n_min, n_delta, drv_step,
    input  drv_enable_sm, n, n_load, dir_out, busy, done, steps_done
  );

  modport slave (
    input  start, stop_req, target_steps, dir_in, n_start, n_min, n_delta, drv_step,
    output drv_enable_sm, n, n_load, dir_out, busy, done, steps_done
  );
endinterface

// File: rtl/sm_ramp_ctrl.sv
// Move sequencer for the stepper-motor pulse generator. Takes a move command,
// enables the pulse generator, counts returned steps and runs a trapezoidal
// accel / cruise / decel period profile, re-loading the period once per step.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous reset, active low
//   bus    : sm_ramp_ctrl_if slave modport (command in, drive and status out)
// All drive and status outputs are registered.
module sm_ramp_ctrl #(
  parameter int unsigned Size = 16,
  parameter int unsigned CntW = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  sm_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StAccel, StCruise, StDecel, StFinish} state_e;

  state_e          state_q, state_d;
  logic [Size:0]   n_q, n_d;
  logic [Size:0]   n_start_q, n_start_d;
  logic [Size:0]   n_min_q, n_min_d;
  logic [Size:0]   n_delta_q, n_delta_d;
  logic [CntW-1:0] remain_q, remain_d;
  logic [CntW-1:0] accel_q, accel_d;
  logic [CntW-1:0] steps_q, steps_d;
  logic            en_q, en_d;
  logic            load_q, load_d;
  logic            dir_q, dir_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            step_prev_q;

  logic            step_evt;
  logic [Size:0]   n_down;
  logic [Size:0]   n_up;
  logic [Size+1:0] n_sum;

  assign step_evt = bus.drv_step & ~step_prev_q;

  // Saturating period arithmetic: never below n_min, never above n_start.
  always_comb begin
    if (n_q <= n_min_q || (n_q - n_min_q) <= n_delta_q) begin
      n_down = n_min_q;
    end else begin
      n_down = n_q - n_delta_q;
    end
    n_sum = {1'b0, n_q} + {1'b0, n_delta_q};
    if (n_sum >= {1'b0, n_start_q}) begin
      n_up = n_start_q;
    end else begin
      n_up = n_sum[Size:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    n_start_d = n_start_q;
    n_min_d   = n_min_q;
    n_delta_d = n_delta_q;
    remain_d  = remain_q;
    accel_d   = accel_q;
    steps_d   = steps_q;
    en_d      = en_q;
    load_d    = 1'b0;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          remain_d  = bus.target_steps;
          accel_d   = '0;
          steps_d   = '0;
          dir_d     = bus.dir_in;
          n_start_d = bus.n_start;
          // A cruise period slower than the start period means "no ramp".
          n_min_d   = (bus.n_min > bus.n_start) ? bus.n_start : bus.n_min;
          n_delta_d = bus.n_delta;
          busy_d    = 1'b1;
          if (bus.target_steps == '0) begin
            state_d = StFinish;
          end else begin
            state_d = StAccel;
            n_d     = bus.n_start;
            load_d  = 1'b1;
            en_d    = 1'b1;
          end
        end
      end

      StAccel, StCruise, StDecel: begin
        // The step is always booked against the state it arrived in.
        if (step_evt) begin
          steps_d  = steps_q + CntW'(1);
          remain_d = (remain_q != '0) ? remain_q - CntW'(1) : '0;
          if (state_q == StAccel) begin
            accel_d = accel_q + CntW'(1);
            n_d     = n_down;
            load_d  = 1'b1;
          end else if (state_q == StDecel) begin
            n_d    = n_up;
            load_d = 1'b1;
          end
        end

        if (bus.stop_req && state_q != StDecel) begin
          // Controlled stop: only as many steps as it takes to ramp back down.
          if (accel_d < remain_d) begin
            remain_d = accel_d;
          end
          state_d = StDecel;
        end else if (step_evt && state_q != StDecel) begin
          if (remain_d <= accel_d) begin
            state_d = StDecel;
          end else if (state_q == StAccel && n_d == n_min_q) begin
            state_d = StCruise;
          end
        end

        if (remain_d == '0) begin
          state_d = StFinish;
          en_d    = 1'b0;
        end
      end

      StFinish: begin
        state_d = StIdle;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      n_q         <= '0;
      n_start_q   <= '0;
      n_min_q     <= '0;
      n_delta_q   <= '0;
      remain_q    <= '0;
      accel_q     <= '0;
      steps_q     <= '0;
      en_q        <= 1'b0;
      load_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      n_start_q   <= n_start_d;
      n_min_q     <= n_min_d;
      n_delta_q   <= n_delta_d;
      remain_q    <= remain_d;
      accel_q     <= accel_d;
      steps_q     <= steps_d;
      en_q        <= en_d;
      load_q      <= load_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_prev_q <= bus.drv_step;
    end
  end

  assign bus.drv_enable_sm = en_q;
  assign bus.n             = n_q;
  assign bus.n_load        = load_q;
  assign bus.dir_out       = dir_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.steps_done    = steps_q;

endmodule
